// File: rtl/alu_pkg.sv
// Shared ALU control codes, ARM data-processing opcodes and sequencer state encoding.
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_CMP  = 4'd2;
   localparam logic [3:0] ALU_PASS = 4'd3;
   localparam logic [3:0] ALU_MUL  = 4'd4;
   localparam logic [3:0] ALU_ORR  = 4'd7;
   localparam logic [3:0] ALU_AND  = 4'd8;
   localparam logic [3:0] ALU_SHL  = 4'd15;

   localparam logic [3:0] OPC_AND = 4'b0000;
   localparam logic [3:0] OPC_SUB = 4'b0010;
   localparam logic [3:0] OPC_ADD = 4'b0100;
   localparam logic [3:0] OPC_CMP = 4'b1010;
   localparam logic [3:0] OPC_ORR = 4'b1100;
   localparam logic [3:0] OPC_MOV = 4'b1101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DECODE,
      ST_EXEC,
      ST_WB
   } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Issue handshake, register-file ports and ALU ports of the op sequencer.
interface alu_op_sequencer_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4
);
   logic              instrValid;
   logic              instrReady;
   logic [31:0]       instr;
   logic [REG_AW-1:0] rnAddr;
   logic [REG_AW-1:0] rmAddr;
   logic [DATA_W-1:0] rnData;
   logic [DATA_W-1:0] rmData;
   logic [DATA_W-1:0] aluIn1;
   logic [DATA_W-1:0] aluIn2;
   logic [3:0]        aluCtrl;
   logic [DATA_W-1:0] aluOut;
   logic              aluZr;
   logic              aluNeg;
   logic              wrEn;
   logic [REG_AW-1:0] wrAddr;
   logic [DATA_W-1:0] wrData;
   logic              flagZ;
   logic              flagN;
   logic              done;
   logic              illegal;

   // master: issue stage, register file and ALU; slave: the sequencer
   modport master (
      output instrValid, instr, rnData, rmData, aluOut, aluZr, aluNeg,
      input  instrReady, rnAddr, rmAddr, aluIn1, aluIn2, aluCtrl,
             wrEn, wrAddr, wrData, flagZ, flagN, done, illegal
   );

   modport slave (
      input  instrValid, instr, rnData, rmData, aluOut, aluZr, aluNeg,
      output instrReady, rnAddr, rmAddr, aluIn1, aluIn2, aluCtrl,
             wrEn, wrAddr, wrData, flagZ, flagN, done, illegal
   );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational decode of an ARM data-processing word into ALU control and legality.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [31:0] instr,
   output logic [3:0]  alu_code,
   output logic        use_imm,
   output logic        writes_rd,
   output logic        illegal
);
   logic known;
   logic unused_bits;

   // cond, S, Rn and operand-2 payload do not affect decode
   assign unused_bits = ^{instr[31:28], instr[20:16], instr[7:0]};

   always_comb begin
      alu_code = ALU_PASS;
      known    = 1'b1;
      case (instr[24:21])
         OPC_AND: alu_code = ALU_AND;
         OPC_SUB: alu_code = ALU_SUB;
         OPC_ADD: alu_code = ALU_ADD;
         OPC_CMP: alu_code = ALU_CMP;
         OPC_ORR: alu_code = ALU_ORR;
         OPC_MOV: alu_code = ALU_PASS;
         default: known    = 1'b0;
      endcase
      use_imm   = instr[25];
      writes_rd = (instr[24:21] != OPC_CMP);
      illegal   = !known
               || (instr[27:26] != 2'b00)
               || (instr[25] && (instr[11:8] != 4'd0))
               || (writes_rd && (instr[15:12] == 4'hF));
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Four-state sequencer: accept, read operands, drive the ALU, write back or harvest CMP flags.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4
) (
   input logic clock,
   input logic reset,
   alu_op_sequencer_if.slave bus
);
   seq_state_e        state;
   logic [31:0]       instr_q;
   logic [3:0]        dec_code;
   logic              dec_imm;
   logic              dec_wr;
   logic              dec_illegal;
   logic [DATA_W-1:0] op2_sel;

   alu_op_decode u_decode (
      .instr     (instr_q),
      .alu_code  (dec_code),
      .use_imm   (dec_imm),
      .writes_rd (dec_wr),
      .illegal   (dec_illegal)
   );

   assign op2_sel = dec_imm ? DATA_W'(instr_q[7:0]) : bus.rmData;

   // Instruction word is held from accept until the next accept; no reset needed.
   always_ff @(posedge clock) begin
      if (state == ST_IDLE && bus.instrValid) begin
         instr_q <= bus.instr;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= ST_IDLE;
         bus.instrReady <= 1'b1;
         bus.rnAddr     <= '0;
         bus.rmAddr     <= '0;
         bus.aluIn1     <= '0;
         bus.aluIn2     <= '0;
         bus.aluCtrl    <= ALU_PASS;
         bus.wrEn       <= 1'b0;
         bus.wrAddr     <= '0;
         bus.wrData     <= '0;
         bus.flagZ      <= 1'b0;
         bus.flagN      <= 1'b0;
         bus.done       <= 1'b0;
         bus.illegal    <= 1'b0;
      end else begin
         bus.aluIn1  <= '0;
         bus.aluIn2  <= '0;
         bus.aluCtrl <= ALU_PASS;
         bus.wrEn    <= 1'b0;
         bus.wrAddr  <= '0;
         bus.wrData  <= '0;
         bus.done    <= 1'b0;
         bus.illegal <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.instrValid) begin
                  state          <= ST_DECODE;
                  bus.instrReady <= 1'b0;
                  bus.rnAddr     <= bus.instr[19:16];
                  bus.rmAddr     <= bus.instr[3:0];
               end
            end
            ST_DECODE: begin
               bus.rnAddr <= '0;
               bus.rmAddr <= '0;
               if (dec_illegal) begin
                  state       <= ST_WB;
                  bus.done    <= 1'b1;
                  bus.illegal <= 1'b1;
               end else begin
                  state       <= ST_EXEC;
                  bus.aluIn1  <= bus.rnData;
                  bus.aluIn2  <= op2_sel;
                  bus.aluCtrl <= dec_code;
               end
            end
            ST_EXEC: begin
               state    <= ST_WB;
               bus.done <= 1'b1;
               if (dec_wr) begin
                  bus.wrEn   <= 1'b1;
                  bus.wrAddr <= instr_q[15:12];
                  bus.wrData <= bus.aluOut;
               end
            end
            ST_WB: begin
               state          <= ST_IDLE;
               bus.instrReady <= 1'b1;
               // ALU flag register was updated at the end of the CMP EXEC cycle
               if (!bus.illegal && !dec_wr) begin
                  bus.flagZ <= bus.aluZr;
                  bus.flagN <= bus.aluNeg;
               end
            end
            default: begin
               state          <= ST_IDLE;
               bus.instrReady <= 1'b1;
            end
         endcase
      end
   end

endmodule
